// File: rtl/dmem_arb.sv
// dmem_arb: arbiter and access sequencer in front of the single-port data memory.
//
// Two requesters share the memory: the CPU load/store path (c_*) and a
// host/loader port (h_*). One winning command is registered in IDLE, issued
// to the memory for exactly one cycle in ACCESS, and answered in RESP. Each
// transaction therefore takes three cycles, and busy is high while one is
// in flight.
//
// Parameters:
//   AW - address width
//   DW - data width
//
// Ports:
//   clk                      system clock, all state on the rising edge
//   reset                    asynchronous, active-low clear of all state
//   c_req/c_we/c_addr/c_wdata   CPU command (held until c_gnt)
//   c_gnt                    one-cycle pulse, CPU command is at the memory
//   c_rvalid/c_rdata         CPU read response (rdata held until next CPU read)
//   h_*                      host port, same meaning as the CPU port
//   mem_cs/mem_r/mem_w       memory chip select and read/write strobes
//   mem_addr/mem_wdata       memory address and write data
//   mem_rdata                memory read data, valid combinationally in ACCESS
//   busy                     high whenever a transaction is in flight
//
// Build option:
//   DMEM_ARB_RR_EN  when defined, ties are resolved round-robin using a
//                   one-bit last-winner pointer; otherwise the CPU always
//                   wins a tie.

module dmem_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          mem_cs,
  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  // Registered command; cmd_owner is 1 when the host owns it.
  logic          cmd_owner;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] h_rdata_q;

  logic          any_req;
  logic          win_h;

  assign any_req = c_req | h_req;

`ifdef DMEM_ARB_RR_EN
  // Last winner: 1 = host. Resetting to host hands the CPU the first tie.
  logic last_h;

  // On a tie the port that did not win last time gets the grant.
  assign win_h = h_req & (~c_req | ~last_h);

  // The pointer only moves when a command is accepted for issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_h <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_h <= win_h;
    end
  end
`else
  // Fixed priority: the host only wins when the CPU is not asking.
  assign win_h = h_req & ~c_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A transaction always runs IDLE -> ACCESS -> RESP -> IDLE; requests are
  // only looked at in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = any_req ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command capture in IDLE, and read-data capture at the end of ACCESS into
  // the owner's own register so the other port's data is never disturbed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_owner <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        cmd_owner <= win_h;
        cmd_we    <= win_h ? h_we    : c_we;
        cmd_addr  <= win_h ? h_addr  : c_addr;
        cmd_wdata <= win_h ? h_wdata : c_wdata;
      end
      if (state == ACCESS && !cmd_we) begin
        if (cmd_owner) begin
          h_rdata_q <= mem_rdata;
        end else begin
          c_rdata_q <= mem_rdata;
        end
      end
    end
  end

  // Outputs decode straight from state, so an asynchronous reset drops the
  // memory strobes in the same cycle. Address and data are forced to zero
  // outside ACCESS.
  always_comb begin
    mem_cs    = 1'b0;
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    c_gnt     = 1'b0;
    h_gnt     = 1'b0;
    c_rvalid  = 1'b0;
    h_rvalid  = 1'b0;
    if (state == ACCESS) begin
      mem_cs    = 1'b1;
      mem_r     = ~cmd_we;
      mem_w     = cmd_we;
      mem_addr  = cmd_addr;
      mem_wdata = cmd_wdata;
      c_gnt     = ~cmd_owner;
      h_gnt     = cmd_owner;
    end
    if (state == RESP && !cmd_we) begin
      c_rvalid = ~cmd_owner;
      h_rvalid = cmd_owner;
    end
  end

  assign busy    = (state != IDLE);
  assign c_rdata = c_rdata_q;
  assign h_rdata = h_rdata_q;

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed self-checking bench for dmem_arb.
//
// A small word-addressed memory model (64 words, indexed by addr[7:2])
// answers the DUT's strobes. Inputs change on the falling edge and outputs
// are sampled on the falling edge, so "cycle N" below means the sample
// taken N falling edges after the request was raised in IDLE.
// Honours DMEM_ARB_RR_EN to select the arbitration scenario.

module tb_dmem_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;
  logic          mem_cs;
  logic          mem_r;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks;
  int errors;

  logic [DW-1:0] mem [0:63];

  dmem_arb #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .h_req     (h_req),
    .h_we      (h_we),
    .h_addr    (h_addr),
    .h_wdata   (h_wdata),
    .h_gnt     (h_gnt),
    .h_rvalid  (h_rvalid),
    .h_rdata   (h_rdata),
    .mem_cs    (mem_cs),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write at the clock edge.
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_w) mem[mem_addr[7:2]] = mem_wdata;
  end

  task automatic applyReset();
    reset   = 1'b0;
    c_req   = 1'b0;
    c_we    = 1'b0;
    c_addr  = '0;
    c_wdata = '0;
    h_req   = 1'b0;
    h_we    = 1'b0;
    h_addr  = '0;
    h_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyReset();
    reset = 1'b0;
    #1;
    checks++;
    if ({c_gnt, h_gnt, c_rvalid, h_rvalid, mem_cs, mem_r, mem_w, busy} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000000",
               {c_gnt, h_gnt, c_rvalid, h_rvalid, mem_cs, mem_r, mem_w, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, c_rdata, h_rdata} !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h want 0",
               {mem_addr, mem_wdata, c_rdata, h_rdata});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    applyReset();
    mem[4] = 32'hDEAD_BEEF;
    c_req  = 1'b1;
    c_we   = 1'b0;
    c_addr = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({c_gnt, h_gnt, mem_cs, mem_r, mem_w, busy} !== 6'b101101) begin
      errors++;
      $display("[TB] FAIL cpu_read_c1: got %b want 101101",
               {c_gnt, h_gnt, mem_cs, mem_r, mem_w, busy});
    end
    checks++;
    if (mem_addr !== 32'h0000_0010) begin
      errors++;
      $display("[TB] FAIL cpu_read_addr: got %h want 00000010", mem_addr);
    end
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({c_rvalid, h_rvalid, mem_cs, busy} !== 4'b1001 || c_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL cpu_read_c2: got ctl %b data %h want 1001 deadbeef",
               {c_rvalid, h_rvalid, mem_cs, busy}, c_rdata);
    end
    @(negedge clk);
    checks++;
    if ({c_rvalid, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL cpu_read_c3: got %b want 00", {c_rvalid, busy});
    end
  endtask

  task automatic test_host_write_cpu_read();
    int wcount;
    int hrv;
    applyReset();
    wcount  = 0;
    hrv     = 0;
    h_req   = 1'b1;
    h_we    = 1'b1;
    h_addr  = 32'h0000_0020;
    h_wdata = 32'h1234_5678;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if ({h_gnt, c_gnt, mem_w, mem_r} !== 4'b1010 || mem_wdata !== 32'h1234_5678) begin
          errors++;
          $display("[TB] FAIL host_write_c1: got %b data %h want 1010 12345678",
                   {h_gnt, c_gnt, mem_w, mem_r}, mem_wdata);
        end
        h_req = 1'b0;
      end
      wcount += int'(mem_w);
      hrv    += int'(h_rvalid);
    end
    c_req  = 1'b1;
    c_we   = 1'b0;
    c_addr = 32'h0000_0020;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) c_req = 1'b0;
      wcount += int'(mem_w);
      hrv    += int'(h_rvalid);
    end
    checks++;
    if (wcount != 1) begin
      errors++;
      $display("[TB] FAIL host_write_pulses: got %0d want 1", wcount);
    end
    checks++;
    if (hrv != 0) begin
      errors++;
      $display("[TB] FAIL host_write_rvalid: got %0d want 0", hrv);
    end
    checks++;
    if (c_rdata !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL host_write_readback: got %h want 12345678", c_rdata);
    end
  endtask

  task automatic test_contention();
    applyReset();
    c_req  = 1'b1;
    c_we   = 1'b0;
    c_addr = 32'h0000_0010;
    h_req  = 1'b1;
    h_we   = 1'b0;
    h_addr = 32'h0000_0020;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (c_gnt !== (i == 1) || h_gnt !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL contention_c%0d: got c_gnt %b h_gnt %b want %b %b",
                 i, c_gnt, h_gnt, (i == 1), (i == 4));
      end
      if (i == 1) c_req = 1'b0;
      if (i == 4) h_req = 1'b0;
    end
  endtask

`ifdef DMEM_ARB_RR_EN
  task automatic test_round_robin();
    logic exp_c;
    logic exp_h;
    applyReset();
    c_req  = 1'b1;
    c_we   = 1'b0;
    c_addr = 32'h0000_0010;
    h_req  = 1'b1;
    h_we   = 1'b0;
    h_addr = 32'h0000_0020;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_c = (i % 3 == 1) && ((i / 3) % 2 == 0);
      exp_h = (i % 3 == 1) && ((i / 3) % 2 == 1);
      checks++;
      if (c_gnt !== exp_c || h_gnt !== exp_h) begin
        errors++;
        $display("[TB] FAIL rr_c%0d: got c_gnt %b h_gnt %b want %b %b",
                 i, c_gnt, h_gnt, exp_c, exp_h);
      end
    end
    c_req = 1'b0;
    h_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`else
  task automatic test_starvation();
    int cg;
    int hg;
    applyReset();
    cg     = 0;
    hg     = 0;
    c_req  = 1'b1;
    c_we   = 1'b0;
    c_addr = 32'h0000_0010;
    h_req  = 1'b1;
    h_we   = 1'b0;
    h_addr = 32'h0000_0020;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      cg += int'(c_gnt);
      hg += int'(h_gnt);
    end
    c_req = 1'b0;
    h_req = 1'b0;
    checks++;
    if (cg != 4 || hg != 0) begin
      errors++;
      $display("[TB] FAIL starvation: got c_gnt %0d h_gnt %0d want 4 0", cg, hg);
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_access();
    int gcount;
    applyReset();
    mem[12] = 32'h0;
    gcount  = 0;
    c_req   = 1'b1;
    c_we    = 1'b1;
    c_addr  = 32'h0000_0030;
    c_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({c_gnt, mem_w} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre: got %b want 11", {c_gnt, mem_w});
    end
    #2;
    reset = 1'b0;
    c_req = 1'b0;
    #1;
    checks++;
    if ({c_gnt, h_gnt, c_rvalid, h_rvalid, mem_cs, mem_r, mem_w, busy} !== 8'h00 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got %b addr %h data %h want 0",
               {c_gnt, h_gnt, c_rvalid, h_rvalid, mem_cs, mem_r, mem_w, busy},
               mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gcount += int'(busy) + int'(c_gnt) + int'(mem_w);
    end
    checks++;
    if (gcount != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle: got %0d activity cycles want 0", gcount);
    end
    checks++;
    if (mem[12] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_nowrite: got %h want 00000000", mem[12]);
    end
  endtask

  task automatic test_rdata_isolation();
    int hrv;
    applyReset();
    hrv     = 0;
    mem[16] = 32'hAAAA_AAAA;
    mem[17] = 32'h5555_5555;
    h_req   = 1'b1;
    h_we    = 1'b0;
    h_addr  = 32'h0000_0040;
    @(negedge clk);
    h_req = 1'b0;
    @(negedge clk);
    checks++;
    if (h_rvalid !== 1'b1 || h_rdata !== 32'hAAAA_AAAA) begin
      errors++;
      $display("[TB] FAIL iso_host_read: got %b %h want 1 aaaaaaaa", h_rvalid, h_rdata);
    end
    @(negedge clk);
    c_req  = 1'b1;
    c_we   = 1'b0;
    c_addr = 32'h0000_0044;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) c_req = 1'b0;
      hrv += int'(h_rvalid);
    end
    checks++;
    if (c_rdata !== 32'h5555_5555) begin
      errors++;
      $display("[TB] FAIL iso_cpu_read: got %h want 55555555", c_rdata);
    end
    checks++;
    if (h_rdata !== 32'hAAAA_AAAA || hrv != 0) begin
      errors++;
      $display("[TB] FAIL iso_host_hold: got %h rvalid %0d want aaaaaaaa 0", h_rdata, hrv);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_cpu_read();
    test_host_write_cpu_read();
    test_contention();
`ifdef DMEM_ARB_RR_EN
    test_round_robin();
`else
    test_starvation();
`endif
    test_reset_mid_access();
    test_rdata_isolation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
